// File: rtl/memory_ram_pkg.sv
// Shared constants for memory_ram: default geometry and the wr_rd request encoding.
package memory_ram_pkg;

    localparam int unsigned DefW = 4;
    localparam int unsigned DefD = 16;

    localparam logic WRITE = 1'b1;
    localparam logic READ  = 1'b0;

endpackage

// File: rtl/memory_ram.sv
// Single-port synchronous RAM with a one-cycle valid/ready handshake.
// The storage array is the mem port itself so backdoor load/dump act on real state.
module memory_ram
    import memory_ram_pkg::*;
#(
    parameter int unsigned W = DefW,
    parameter int unsigned D = DefD,
    localparam int unsigned N = $clog2(D)
) (
    input  logic         clk,
    input  logic         res,
    input  logic         wr_rd,
    input  logic [N-1:0] addr,
    input  logic [W-1:0] wdata,
    input  logic         valid,
    output logic [W-1:0] rdata,
    output logic         ready,
    output logic [W-1:0] mem [D]
);

    always_ff @(posedge clk) begin
        if (res) begin
            // Reset wins over any request sampled on the same edge.
            mem   <= '{default: '0};
            rdata <= '0;
            ready <= 1'b0;
        end else begin
            ready <= valid;
            if (valid) begin
                if (wr_rd == WRITE) begin
                    mem[addr] <= wdata;
                end else begin
                    rdata <= mem[addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_ram.sv
// Scoreboard bench for memory_ram: driver updates a behavioural array model per edge,
// a negedge monitor pops expected ready/rdata and compares the mem view.
module tb_memory_ram;

    localparam int unsigned W = 4;
    localparam int unsigned D = 16;

    typedef struct packed {
        logic         rdy;
        logic [W-1:0] rd;
    } exp_t;

    logic         clk = 1'b0;
    logic         res = 1'b0;
    logic         wr_rd = 1'b0;
    logic [3:0]   addr = '0;
    logic [W-1:0] wdata = '0;
    logic         valid = 1'b0;
    logic [W-1:0] rdata;
    logic         ready;
    logic [W-1:0] mem [D];

    int n_chk  = 0;
    int n_fail = 0;

    exp_t         exp_q[$];
    bit           armed = 1'b0;
    int           ref_mem [D];
    int           ref_rdata = 0;
    int           ref_rdy = 0;

    memory_ram #(
        .W(W),
        .D(D)
    ) dut (
        .clk   (clk),
        .res   (res),
        .wr_rd (wr_rd),
        .addr  (addr),
        .wdata (wdata),
        .valid (valid),
        .rdata (rdata),
        .ready (ready),
        .mem   (mem)
    );

    always #5 clk = ~clk;

    // One clock cycle of stimulus; the model is plain integer array semantics.
    task automatic cyc(input bit r, input bit v, input bit w, input int a, input int d);
        int ai;
        int di;
        ai = a % D;           // index D wraps to 0
        di = d % (1 << W);    // data taken modulo 2^W
        res   = r;
        valid = v;
        wr_rd = w;
        addr  = 4'(ai);
        wdata = W'(di);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < int'(D); i++) ref_mem[i] = 0;
            ref_rdata = 0;
            ref_rdy   = 0;
        end else begin
            ref_rdy = v ? 1 : 0;
            if (v && w) ref_mem[ai] = di;
            else if (v) ref_rdata = ref_mem[ai];
        end
        exp_q.push_back('{rdy: (ref_rdy != 0), rd: W'(ref_rdata)});
        armed = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   bad;
        if (armed) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: no expected entry at time %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (ready !== e.rdy) begin
                    n_fail++;
                    $display("FAIL ready: got %b want %b at %0t", ready, e.rdy, $time);
                end
                n_chk++;
                if (rdata !== e.rd) begin
                    n_fail++;
                    $display("FAIL rdata: got %h want %h at %0t", rdata, e.rd, $time);
                end
            end
            n_chk++;
            bad = -1;
            for (int i = 0; i < int'(D); i++) begin
                if (bad < 0 && mem[i] !== W'(ref_mem[i])) bad = i;
            end
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL mem_view[%0d]: got %h want %h at %0t",
                         bad, mem[bad], W'(ref_mem[bad]), $time);
            end
        end
    end

    initial begin
        // Reset with valid low.
        cyc(1, 0, 0, 0, 0);
        // Forward writes 0..3 with (16-i) mod 16, then reads.
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, i, 16 - i);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, i, 0);
        // Back-to-back read-after-write on addr 5, valid held high.
        cyc(0, 1, 1, 5, 'hB);
        cyc(0, 1, 0, 5, 0);
        // Fill mem[i]=i then read everything back; address 16 wraps to 0.
        for (int i = 0; i < 16; i++) cyc(0, 1, 1, i, i);
        for (int i = 0; i <= 16; i++) cyc(0, 1, 0, i, 0);
        // Single write at 8, other words must stay put in the mem view.
        cyc(0, 1, 1, 8, 7);
        cyc(0, 1, 0, 8, 0);
        // Idle for two cycles.
        cyc(0, 0, 0, 3, 9);
        cyc(0, 0, 1, 3, 9);
        // Reset sampled together with a write: write dropped, array cleared.
        cyc(0, 1, 1, 2, 9);
        cyc(1, 1, 1, 2, 9);
        cyc(0, 1, 0, 2, 0);
        // Randomized traffic with occasional resets and wide data.
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                $urandom_range(0, 1), $urandom_range(0, 16), $urandom_range(0, 40));
        end
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_ram.md
# memory_ram

Single-port synchronous RAM of D words × W bits behind a valid/ready request handshake, with a full-array view exposed for backdoor load and dump. It serves as the generic scratch memory in the design and as the standard target for memory directed tests. One request per cycle: write when `wr_rd`=1, read when `wr_rd`=0.

## Interface
Parameters:
- `W`, default 4: data word width.
- `D`, default 16: depth in words; must be a power of two.
- `N`, default $clog2(D): address width; derived, not overridden.

Ports:
- `clk`  input  1: the single clock; all state updates on its rising edge.
- `res`  input  1: reset; synchronous, active-high.
- `wr_rd`  input  1: 1 = write request, 0 = read request.
- `addr`  input  N: word address.
- `wdata`  input  W: write data.
- `valid`  input  1: request present this cycle.
- `rdata`  output  W: read data, registered.
- `ready`  output  1: request accepted/completed, registered.
- `mem`  output  D×W unpacked array: the storage array itself, continuously visible.
  - The internal storage array is this port, named `mem`.
  - Hierarchical `$readmemh`/`$readmemb`/`$writememh`/`$writememb` on `<inst>.mem` must act on the real storage.

## Operation
- Rising edge with `res`=1:
  - all `mem` words ← 0
  - `rdata` ← 0
  - `ready` ← 0
  - any in-flight request is discarded
- Rising edge with `res`=0 and `valid`=1, `wr_rd`=1: `mem[addr]` ← `wdata`; `rdata` holds; `ready` ← 1.
- Rising edge with `res`=0 and `valid`=1, `wr_rd`=0: `rdata` ← `mem[addr]` (pre-edge contents); `ready` ← 1.
- Rising edge with `res`=0 and `valid`=0: `ready` ← 0; `mem` and `rdata` hold.
- Address and data width rules:
  - `addr` is exactly N bits; callers truncate wider indices, so index D maps to 0.
  - `wdata` is taken as-is, W bits; callers truncate wider values modulo 2^W.
- No FSM beyond the `ready` register. Every valid request completes in one cycle; there is no backpressure.
- Backdoor loads of `mem` between edges are legal and immediately visible to subsequent reads.

## Timing
- Latency is 1 cycle: request sampled at edge k, so `ready`=1 and read `rdata` are valid after edge k.
- `ready` follows `valid` delayed by one cycle. Holding `valid`=1 continuously gives back-to-back transactions with `ready` held high, one per cycle.
- Write followed by read of the same address on the next cycle returns the new data (read-after-write, 1-cycle spacing).
- Reset outputs: `rdata`=0, `ready`=0, `mem`=all zeros, all valid after the first reset edge.
- Reset asserted mid-stream: reset wins over `valid`, and `ready` drops after that edge.
  - A write sampled on the reset edge is not performed.

## Structure
- Shared package: default `W`/`D` constants and the `wr_rd` encoding constants (WRITE=1, READ=0).
- Single flat module; no sub-module needed. The storage array plus two output registers is the whole datapath.

## Test plan
- Reset: hold `res`=1 for one edge with `valid`=0 → `ready`=0, `rdata`=0, `mem[0..15]`=0.
- Forward write/read: write addr 0..3 with data (16−i) mod 16 (0, F, E, D), then read 0..3.
  - `ready`=1 one cycle after each request.
  - Read `rdata` = 0, F, E, D.
  - `mem` view matches after the writes.
- Back-to-back RAW: write addr 5 = B at cycle k, read addr 5 at k+1 → `rdata`=B after k+1 edge; `valid` held high throughout, `ready` stays 1.
- Backdoor load then frontdoor read: `$readmemh` a pattern (e.g. mem[i]=i) into `mem` → reads of addr 0..15 return 0..F.
- Frontdoor write then backdoor dump: write addr 8 = 7 → `$writememh` output shows 7 at word 8, and other words are unchanged.
- Idle/reset interaction:
  - `valid`=0 for 2 cycles → `ready`=0, `mem`/`rdata` unchanged.
  - Assert `res` with `valid`=1, `wr_rd`=1 → write is not performed, `mem` is cleared, `ready`=0.
